// File: rtl/cross3_pkg.sv
// Shared types and the six-step multiply/accumulate schedule for cross3_seq.
package cross3_pkg;

  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {COMP_X = 2'd0, COMP_Y = 2'd1, COMP_Z = 2'd2} comp_t;
  typedef logic [2:0] step_t;

  typedef struct packed {
    comp_t sel_a;
    comp_t sel_b;
    comp_t dest;
    logic  sub;
  } sched_t;

  // Even steps seed a component with the first product; odd steps subtract the second.
  function automatic sched_t sched(input step_t s);
    sched_t r;
    r = '{sel_a: COMP_X, sel_b: COMP_X, dest: COMP_X, sub: 1'b0};
    case (s)
      3'd0: r = '{sel_a: COMP_Y, sel_b: COMP_Z, dest: COMP_X, sub: 1'b0};
      3'd1: r = '{sel_a: COMP_Z, sel_b: COMP_Y, dest: COMP_X, sub: 1'b1};
      3'd2: r = '{sel_a: COMP_Z, sel_b: COMP_X, dest: COMP_Y, sub: 1'b0};
      3'd3: r = '{sel_a: COMP_X, sel_b: COMP_Z, dest: COMP_Y, sub: 1'b1};
      3'd4: r = '{sel_a: COMP_X, sel_b: COMP_Y, dest: COMP_Z, sub: 1'b0};
      3'd5: r = '{sel_a: COMP_Y, sel_b: COMP_X, dest: COMP_Z, sub: 1'b1};
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cross3_mul.sv
// Shared signed DWxDW multiplier; CROSS3_PIPE_MUL_EN adds an output register.
module cross3_mul #(
  parameter int DW = 8
) (
`ifdef CROSS3_PIPE_MUL_EN
  input  logic                   clk,
  input  logic                   rst_n,
`endif
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [2*DW-1:0] p
);

  logic signed [2*DW-1:0] prod;

  assign prod = (2*DW)'(a) * (2*DW)'(b);

`ifdef CROSS3_PIPE_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else        p <= prod;
  end
`else
  assign p = prod;
`endif

endmodule

// File: rtl/cross3_seq.sv
// Sequenced 3-D signed cross product c = a x b using one shared multiplier.
// Optional macro CROSS3_PIPE_MUL_EN registers the product, adding one CALC cycle.
module cross3_seq
  import cross3_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [DW-1:0]   a_x,
  input  logic signed [DW-1:0]   a_y,
  input  logic signed [DW-1:0]   a_z,
  input  logic signed [DW-1:0]   b_x,
  input  logic signed [DW-1:0]   b_y,
  input  logic signed [DW-1:0]   b_z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [2*DW-1:0] c_x,
  output logic signed [2*DW-1:0] c_y,
  output logic signed [2*DW-1:0] c_z,
  output logic                   busy
);

`ifdef CROSS3_PIPE_MUL_EN
  localparam step_t LAST_STEP = 3'd6;
`else
  localparam step_t LAST_STEP = 3'd5;
`endif

  state_t state, state_d;
  step_t  step, step_d;
  logic   in_ready_d, out_valid_d;
  logic   accept, acc_en;
  sched_t issue_s, acc_s;

  logic signed [DW-1:0]   a_q [3];
  logic signed [DW-1:0]   b_q [3];
  logic signed [2*DW-1:0] c_q [3];
  logic signed [DW-1:0]   mul_a, mul_b;
  logic signed [2*DW-1:0] prod;

  assign accept = (state == IDLE) && in_valid && in_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      step      <= step_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state;
    step_d      = step;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    case (state)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready) begin
          in_ready_d = 1'b0;
          step_d     = '0;
          state_d    = CALC;
        end
      end
      CALC: begin
        step_d = step + 3'd1;
        if (step == LAST_STEP) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With the product register, accumulation trails the issued multiply by one step.
  assign issue_s = sched(step);
`ifdef CROSS3_PIPE_MUL_EN
  assign acc_s  = sched(step - 3'd1);
  assign acc_en = (step != 3'd0);
`else
  assign acc_s  = issue_s;
  assign acc_en = 1'b1;
`endif

  assign mul_a = a_q[issue_s.sel_a];
  assign mul_b = b_q[issue_s.sel_b];

  cross3_mul #(.DW(DW)) u_mul (
`ifdef CROSS3_PIPE_MUL_EN
    .clk   (clk),
    .rst_n (rst_n),
`endif
    .a     (mul_a),
    .b     (mul_b),
    .p     (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        a_q[0] <= a_x;
        a_q[1] <= a_y;
        a_q[2] <= a_z;
        b_q[0] <= b_x;
        b_q[1] <= b_y;
        b_q[2] <= b_z;
      end
      if (state == CALC && acc_en)
        c_q[acc_s.dest] <= acc_s.sub ? (c_q[acc_s.dest] - prod) : prod;
    end
  end

  assign c_x = c_q[0];
  assign c_y = c_q[1];
  assign c_z = c_q[2];

endmodule

// File: tb/tb_cross3_seq.sv
// Self-checking bench for cross3_seq: vector table, scoreboard queue and corner sequences.
module tb_cross3_seq;

  localparam int DW = 8;
`ifdef CROSS3_PIPE_MUL_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif

  typedef struct {
    int ax, ay, az, bx, by, bz;
    int cx, cy, cz;
  } vec_t;

  typedef struct {
    int cx, cy, cz;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic signed [DW-1:0]   a_x, a_y, a_z, b_x, b_y, b_z;
  logic signed [2*DW-1:0] c_x, c_y, c_z;

  int   checks = 0;
  int   failures = 0;
  res_t sb[$];
  vec_t tbl[10];

  cross3_seq #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_x       (a_x),
    .a_y       (a_y),
    .a_z       (a_z),
    .b_x       (b_x),
    .b_y       (b_y),
    .b_z       (b_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_x       (c_x),
    .c_y       (c_y),
    .c_z       (c_z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int ax, ay, az, bx, by, bz);
    vec_t v;
    v.ax = ax; v.ay = ay; v.az = az;
    v.bx = bx; v.by = by; v.bz = bz;
    v.cx = ay * bz - az * by;
    v.cy = az * bx - ax * bz;
    v.cz = ax * by - ay * bx;
    return v;
  endfunction

  function automatic int rnd();
    return int'($urandom_range(255)) - 128;
  endfunction

  // Drive a vector, wait (bounded) for acceptance, then scramble operands.
  task automatic applyStimulus(input vec_t v, output int waits);
    a_x = DW'(v.ax); a_y = DW'(v.ay); a_z = DW'(v.az);
    b_x = DW'(v.bx); b_y = DW'(v.by); b_z = DW'(v.bz);
    in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 50) begin
      tick();
      waits++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1 within 50 cycles");
      in_valid = 1'b0;
    end else begin
      tick();
      in_valid = 1'b0;
      sb.push_back('{cx: v.cx, cy: v.cy, cz: v.cz});
      check("in_ready_after_accept", int'(in_ready), 0);
      check("busy_after_accept", int'(busy), 1);
      a_x = DW'(rnd()); a_y = DW'(rnd()); a_z = DW'(rnd());
      b_x = DW'(rnd()); b_y = DW'(rnd()); b_z = DW'(rnd());
    end
  endtask

  task automatic waitValid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic checkOutput();
    res_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty: got result c=(%0d,%0d,%0d), expected none", c_x, c_y, c_z);
    end else begin
      e = sb.pop_front();
      check("out_valid", int'(out_valid), 1);
      check("c_x", int'(c_x), e.cx);
      check("c_y", int'(c_y), e.cy);
      check("c_z", int'(c_z), e.cz);
    end
  endtask

  initial begin
    int   waits, cyc, spurious;
    vec_t gen, pla, ext;

    in_valid = 1'b0; out_ready = 1'b0;
    a_x = '0; a_y = '0; a_z = '0; b_x = '0; b_y = '0; b_z = '0;
    rst_n = 1'b0;

    tbl[0] = mk(1, 0, 0, 0, 1, 0);
    tbl[0].cx = 0; tbl[0].cy = 0; tbl[0].cz = 1;
    tbl[1] = mk(2, 3, 4, 5, 6, 7);
    tbl[1].cx = -3; tbl[1].cy = 6; tbl[1].cz = -3;
    tbl[2] = mk(2, -5, 0, 0, -12, -2);
    tbl[2].cx = 10; tbl[2].cy = 4; tbl[2].cz = -24;
    tbl[3] = mk(0, -128, 127, 0, -128, -128);
    tbl[3].cx = 32640; tbl[3].cy = 0; tbl[3].cz = 0;
    tbl[4] = mk(-128, -128, -128, 127, -128, 127);
    tbl[5] = mk(127, 127, 127, -128, -128, -128);
    for (int i = 6; i < 10; i++) tbl[i] = mk(rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
    gen = tbl[1];
    pla = tbl[2];
    ext = tbl[3];

    repeat (3) tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_c_x", int'(c_x), 0);
    check("rst_c_z", int'(c_z), 0);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", int'(in_ready), 0);
    tick();
    check("in_ready_first_edge", int'(in_ready), 1);

    // Table vectors back to back with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i], waits);
      waitValid(cyc);
      check($sformatf("latency_v%0d", i), cyc, LAT);
      checkOutput();
      tick();
      check($sformatf("out_valid_clear_v%0d", i), int'(out_valid), 0);
      check($sformatf("in_ready_back_v%0d", i), int'(in_ready), 1);
    end

    // Backpressure: result held while a new vector waits with in_valid high.
    out_ready = 1'b0;
    applyStimulus(gen, waits);
    waitValid(cyc);
    check("bp_latency", cyc, LAT);
    a_x = DW'(pla.ax); a_y = DW'(pla.ay); a_z = DW'(pla.az);
    b_x = DW'(pla.bx); b_y = DW'(pla.by); b_z = DW'(pla.bz);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_c_y_stable", int'(c_y), gen.cy);
    end
    checkOutput();
    out_ready = 1'b1;
    tick();
    check("bp_handshake_out_valid", int'(out_valid), 0);
    check("bp_handshake_in_ready", int'(in_ready), 1);
    applyStimulus(pla, waits);
    check("bp_second_accept_wait", waits, 0);
    waitValid(cyc);
    check("bp_second_latency", cyc, LAT);
    checkOutput();
    tick();

    // Reset at step 3 of CALC discards the partial result.
    applyStimulus(gen, waits);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_c_x", int'(c_x), 0);
    check("midrst_c_y", int'(c_y), 0);
    check("midrst_c_z", int'(c_z), 0);
    tick();
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready_held", int'(in_ready), 0);
    tick();
    check("midrst_in_ready_rise", int'(in_ready), 1);
    spurious = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid) spurious++;
    end
    check("midrst_no_spurious", spurious, 0);
    applyStimulus(ext, waits);
    waitValid(cyc);
    check("post_rst_latency", cyc, LAT);
    checkOutput();
    tick();
    check("post_rst_in_ready", int'(in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
